// File: rtl/shift_load_ctrl_if.sv
// Handshake and serial-load bus between an issuing controller and shift_load_ctrl.
interface shift_load_ctrl_if #(
   parameter int unsigned WIDTH = 3
);
   logic             start;
   logic [WIDTH-1:0] din;
   logic             sd;
   logic             sh_en;
   logic             latch;
   logic             busy;
   logic             done;

   // Issuing logic drives the request, observes the serial side and status.
   modport master (
      output start, din,
      input  sd, sh_en, latch, busy, done
   );

   // Sequencer consumes the request and drives the serial side and status.
   modport slave (
      input  start, din,
      output sd, sh_en, latch, busy, done
   );
endinterface

// File: rtl/shift_load_ctrl.sv
// Loads a parallel word MSB-first into a serial-in shift register, one bit
// every DIV clocks, then pulses latch and done. All outputs are registered.
module shift_load_ctrl #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned DIV   = 4
) (
   input logic               clk,
   input logic               rst,
   shift_load_ctrl_if.slave  bus
);
   localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [CW-1:0] BIT_LAST   = CW'(WIDTH - 1);
   // With DIV=1 every SHIFT cycle is a strobe cycle, including the first.
   localparam logic          STROBE_AT_ZERO = (PRESC_LAST == '0);

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] shadow;
   logic [WIDTH-1:0] shadow_shl;
   logic [PW-1:0]    presc;
   logic [PW-1:0]    presc_inc;
   logic [CW-1:0]    bitcnt;
   logic             sd_q;
   logic             sh_en_q;
   logic             latch_q;
   logic             busy_q;
   logic             done_q;

   assign shadow_shl = shadow << 1;
   assign presc_inc  = presc + PW'(1);

   assign bus.sd    = sd_q;
   assign bus.sh_en = sh_en_q;
   assign bus.latch = latch_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

   // Sequencer: next-cycle output values are computed alongside the state so
   // that sd/sh_en/latch/busy/done all come straight from flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         shadow  <= '0;
         presc   <= '0;
         bitcnt  <= '0;
         sd_q    <= 1'b0;
         sh_en_q <= 1'b0;
         latch_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         sh_en_q <= 1'b0;
         latch_q <= 1'b0;
         done_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  shadow  <= bus.din;
                  presc   <= '0;
                  bitcnt  <= '0;
                  sd_q    <= bus.din[WIDTH-1];
                  sh_en_q <= STROBE_AT_ZERO;
                  busy_q  <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               if (presc == PRESC_LAST) begin
                  // Downstream samples sd on this edge; advance to next bit.
                  presc  <= '0;
                  shadow <= shadow_shl;
                  bitcnt <= bitcnt + CW'(1);
                  if (bitcnt == BIT_LAST) begin
                     sd_q    <= 1'b0;
                     latch_q <= 1'b1;
                     state   <= LATCH;
                  end else begin
                     sd_q    <= shadow_shl[WIDTH-1];
                     sh_en_q <= STROBE_AT_ZERO;
                  end
               end else begin
                  presc   <= presc_inc;
                  sh_en_q <= (presc_inc == PRESC_LAST);
               end
            end
            LATCH: begin
               done_q <= 1'b1;
               state  <= DONE;
            end
            DONE: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_shift_load_ctrl.sv
// Bench for shift_load_ctrl: three configurations (3x4, 3x1, 8x2) checked
// every cycle against a timing-rule reference model and a downstream shift
// register, plus a per-cycle vector table and directed corner sequences.
module tb_shift_load_ctrl;
   localparam int NU = 3;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   shift_load_ctrl_if #(.WIDTH(3)) if0 ();
   shift_load_ctrl_if #(.WIDTH(3)) if1 ();
   shift_load_ctrl_if #(.WIDTH(8)) if2 ();

   shift_load_ctrl #(.WIDTH(3), .DIV(4)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
   shift_load_ctrl #(.WIDTH(3), .DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
   shift_load_ctrl #(.WIDTH(8), .DIV(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

   logic       start_a [NU];
   logic [7:0] din_a   [NU];
   logic [4:0] out_a   [NU];   // {sd, sh_en, latch, busy, done}

   assign if0.start = start_a[0];
   assign if0.din   = din_a[0][2:0];
   assign if1.start = start_a[1];
   assign if1.din   = din_a[1][2:0];
   assign if2.start = start_a[2];
   assign if2.din   = din_a[2];

   assign out_a[0] = {if0.sd, if0.sh_en, if0.latch, if0.busy, if0.done};
   assign out_a[1] = {if1.sd, if1.sh_en, if1.latch, if1.busy, if1.done};
   assign out_a[2] = {if2.sd, if2.sh_en, if2.latch, if2.busy, if2.done};

   // Reference model state: one transfer record per DUT.
   bit         m_act    [NU];
   int         m_k      [NU];
   logic [7:0] m_d      [NU];
   logic [7:0] sr       [NU];
   int         npul     [NU];
   logic [7:0] last_lat [NU];
   int         cyc;
   int         n_checks;
   int         n_fail;

   typedef struct packed {
      logic       start;
      logic [2:0] din;
      logic [4:0] exp;
   } vec_t;

   vec_t tbl [16];

   function automatic int wv(int u);
      return (u == 2) ? 8 : 3;
   endfunction

   function automatic int dvv(int u);
      return (u == 0) ? 4 : ((u == 1) ? 1 : 2);
   endfunction

   function automatic logic [7:0] wmask(int u);
      return 8'((1 << wv(u)) - 1);
   endfunction

   // Position in the transfer decides every output: strobes every DIV cycles,
   // bit i held for DIV cycles, latch then done, busy across the whole span.
   function automatic logic [4:0] model_out(int u, logic in_rst);
      int   w;
      int   dv;
      int   t;
      logic s;
      w = wv(u);
      dv = dvv(u);
      if (in_rst || !m_act[u]) return 5'b0;
      t = cyc - m_k[u];
      if (t < 1 || t > w * dv + 2) return 5'b0;
      s = 1'b0;
      if (t <= w * dv) s = m_d[u][w - 1 - (t - 1) / dv];
      return {s, (t <= w * dv) && (t % dv == 0), t == w * dv + 1, 1'b1, t == w * dv + 2};
   endfunction

   task automatic check(string name, int u, logic [7:0] act, logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %h expected %h at %0t", name, u, act, exp, $time);
      end
   endtask

   // Rising edge: model accepts start only when it considers the DUT idle.
   task automatic model_edge();
      for (int u = 0; u < NU; u++) begin
         if (rst) m_act[u] = 1'b0;
         else if (start_a[u] && !model_out(u, 1'b0)[1]) begin
            m_act[u] = 1'b1;
            m_k[u]   = cyc;
            m_d[u]   = din_a[u] & wmask(u);
         end
      end
      cyc++;
   endtask

   // Falling edge: compare all outputs, feed the downstream shift register.
   task automatic model_check();
      logic [4:0] e;
      for (int u = 0; u < NU; u++) begin
         e = model_out(u, rst);
         check("sd",    u, {7'b0, out_a[u][4]}, {7'b0, e[4]});
         check("sh_en", u, {7'b0, out_a[u][3]}, {7'b0, e[3]});
         check("latch", u, {7'b0, out_a[u][2]}, {7'b0, e[2]});
         check("busy",  u, {7'b0, out_a[u][1]}, {7'b0, e[1]});
         check("done",  u, {7'b0, out_a[u][0]}, {7'b0, e[0]});
         if (!rst && m_act[u] && (cyc - m_k[u] == 1)) begin
            sr[u]   = 8'b0;
            npul[u] = 0;
         end
         if (out_a[u][3]) begin
            sr[u] = {sr[u][6:0], out_a[u][4]};
            npul[u]++;
         end
         if (e[2]) begin
            check("latched_word", u, sr[u] & wmask(u), m_d[u]);
            check("pulse_count", u, 8'(npul[u]), 8'(wv(u)));
            last_lat[u] = sr[u] & wmask(u);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      model_check();
   endtask

   task automatic idle_inputs();
      for (int u = 0; u < NU; u++) start_a[u] = 1'b0;
   endtask

   initial begin
      // {start, din, expected {sd, sh_en, latch, busy, done} in the next cycle}
      tbl[0]  = {1'b1, 3'b101, 5'b10010};
      tbl[1]  = {1'b0, 3'b101, 5'b10010};
      tbl[2]  = {1'b0, 3'b101, 5'b10010};
      tbl[3]  = {1'b0, 3'b101, 5'b11010};
      tbl[4]  = {1'b0, 3'b101, 5'b00010};
      tbl[5]  = {1'b1, 3'b010, 5'b00010};
      tbl[6]  = {1'b0, 3'b010, 5'b00010};
      tbl[7]  = {1'b0, 3'b010, 5'b01010};
      tbl[8]  = {1'b0, 3'b010, 5'b10010};
      tbl[9]  = {1'b0, 3'b010, 5'b10010};
      tbl[10] = {1'b0, 3'b010, 5'b10010};
      tbl[11] = {1'b0, 3'b010, 5'b11010};
      tbl[12] = {1'b0, 3'b010, 5'b00110};
      tbl[13] = {1'b0, 3'b010, 5'b00011};
      tbl[14] = {1'b1, 3'b010, 5'b00000};
      tbl[15] = {1'b0, 3'b010, 5'b00000};

      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      rst      = 1'b1;
      for (int u = 0; u < NU; u++) begin
         start_a[u]  = 1'b0;
         din_a[u]    = 8'h00;
         sr[u]       = 8'h00;
         npul[u]     = 0;
         last_lat[u] = 8'h00;
      end
      step();
      step();
      for (int u = 0; u < NU; u++) check("reset_outputs", u, {3'b0, out_a[u]}, 8'h00);
      rst = 1'b0;
      step();

      // Vector table: 3x4 transfer of 101 with ignored starts at cycles 5 and 14.
      for (int i = 0; i < 16; i++) begin
         start_a[0] = tbl[i].start;
         din_a[0]   = {5'b0, tbl[i].din};
         step();
         check($sformatf("vec%0d", i), 0, {3'b0, out_a[0]}, {3'b0, tbl[i].exp});
      end
      idle_inputs();
      check("table_latched", 0, last_lat[0], 8'h05);
      step();

      // Async reset in cycle 9 of a 110 transfer, then a clean 011 transfer.
      start_a[0] = 1'b1;
      din_a[0]   = 8'h06;
      step();
      start_a[0] = 1'b0;
      repeat (7) step();
      @(posedge clk);
      model_edge();
      #2 rst = 1'b1;
      #1 check("async_reset", 0, {3'b0, out_a[0]}, 8'h00);
      @(negedge clk);
      model_check();
      step();
      rst = 1'b0;
      step();
      check("no_latch_after_reset", 0, last_lat[0], 8'h05);
      start_a[0] = 1'b1;
      din_a[0]   = 8'h03;
      step();
      start_a[0] = 1'b0;
      repeat (16) step();
      check("post_reset_word", 0, last_lat[0], 8'h03);

      // DIV=1 with 111 and the 8-bit DIV=2 transfer of A5 in parallel.
      start_a[1] = 1'b1;
      din_a[1]   = 8'h07;
      start_a[2] = 1'b1;
      din_a[2]   = 8'hA5;
      step();
      idle_inputs();
      repeat (20) step();
      check("div1_word", 1, last_lat[1], 8'h07);
      check("w8_word", 2, last_lat[2], 8'hA5);

      // start held high: back-to-back transfers with one idle cycle between.
      start_a[0] = 1'b1;
      din_a[0]   = 8'h04;
      step();
      repeat (2) step();
      din_a[0] = 8'h01;
      repeat (11) step();
      check("held_first_word", 0, last_lat[0], 8'h04);
      step();
      check("held_idle_gap", 0, {7'b0, out_a[0][1]}, 8'h00);
      step();
      start_a[0] = 1'b0;
      repeat (16) step();
      check("held_second_word", 0, last_lat[0], 8'h01);

      // Random traffic on all three configurations.
      for (int c = 0; c < 400; c++) begin
         for (int u = 0; u < NU; u++) begin
            start_a[u] = ($urandom_range(0, 3) == 0);
            din_a[u]   = 8'($urandom);
         end
         step();
      end
      idle_inputs();
      repeat (25) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/shift_load_ctrl.md
Name: shift_load_ctrl

Overview:
- Sequencer that loads a parallel word into a downstream serial-in shift register, one bit per enable strobe, MSB first.
- Produces the serial data bit, a one-cycle shift strobe and a final latch strobe, with a start/busy/done handshake toward the issuing logic.
- Sits between control FSMs or switch/button logic and the serial-in shift register plus its output latch; shift rate is set by a clock prescaler.

Parameters:
- WIDTH, 3, number of bits per transfer (>=1); matches downstream register length.
- DIV, 4, clk cycles per shifted bit (>=1); DIV=1 shifts every cycle.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a transfer; sampled only in IDLE.
- din  input  WIDTH  parallel word; captured on the edge that accepts start.
- sd  output  1  serial data to downstream d input; = MSB of internal shadow register.
- sh_en  output  1  one-cycle shift strobe; downstream register samples sd on the edge where sh_en=1.
- latch  output  1  one-cycle strobe after the last bit; downstream output latch captures.
- busy  output  1  high from start acceptance until done has been asserted.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, any state): state=IDLE; shadow, prescaler, bit counter cleared; sd=0, sh_en=0, latch=0, busy=0, done=0. No latch pulse is produced for an interrupted transfer.
- States: IDLE, SHIFT, LATCH, DONE. All outputs registered or decoded from registered state only; no combinational path from start/din to outputs.
- IDLE: busy=0. start=1 on edge k -> shadow<=din, prescaler<=0, bitcnt<=0, state<=SHIFT; busy=1 from cycle k+1.
- SHIFT: prescaler counts 0..DIV-1, wraps. When prescaler==DIV-1, sh_en=1 that cycle. On that edge, shadow shifts left by 1 (LSB fill 0) and bitcnt increments. sd holds the current shadow MSB for the whole bit period, so the bit i strobe (i=0..WIDTH-1) carries din[WIDTH-1-i].
- After the WIDTH-th strobe, state<=LATCH: latch=1 for exactly one cycle, sd=0, sh_en=0.
- LATCH -> DONE: done=1 for one cycle, busy still 1. DONE -> IDLE.
- Timing with start accepted on edge k: sh_en high in cycles k+DIV, k+2*DIV, ..., k+WIDTH*DIV; latch in cycle k+WIDTH*DIV+1; done in k+WIDTH*DIV+2; busy falls in k+WIDTH*DIV+3. Total busy period = WIDTH*DIV+2 cycles.
- start while busy (SHIFT, LATCH or DONE, including the done cycle): ignored, not queued. din changes while busy: no effect.
- start held continuously high: new transfer accepted on the first IDLE cycle, i.e. one idle cycle between transfers. din is re-sampled at that point.
- sh_en never asserts outside SHIFT. latch and done are never high in the same cycle. Exactly WIDTH sh_en pulses per completed transfer.
- Counter widths: prescaler $clog2(DIV) bits (min 1), bitcnt $clog2(WIDTH+1) bits; no overflow for legal parameters.

Test Plan:
- WIDTH=3, DIV=4, din=3'b101, start on edge 0 -> sh_en in cycles 4, 8, 12 with sd=1, 0, 1; latch cycle 13; done cycle 14; busy 1..14. Behavioural 3-bit shift model fed by sd/sh_en holds 3'b101 at latch.
- Same config, start pulsed again in cycles 5 and 14 with din=3'b010 -> both ignored; exactly 3 sh_en pulses; model still 3'b101; no second busy period.
- Assert rst in cycle 9 of a din=3'b110 transfer -> all outputs 0 immediately; no latch or done; after release, start with din=3'b011 -> normal full sequence, model=3'b011.
- DIV=1, WIDTH=3, din=3'b111 -> sh_en in cycles 1, 2, 3, sd=1 each; latch cycle 4; done cycle 5.
- start held high, din=3'b100 then 3'b001 -> two back-to-back transfers separated by one idle cycle (busy=0); second transfer shifts 0, 0, 1.
- WIDTH=8, DIV=2, din=8'hA5 -> 8 strobes at even cycles 2..16, sd sequence 1,0,1,0,0,1,0,1; latch cycle 17; done cycle 18.
